// File: rtl/crc_share_pkg.sv
// Shared types and default sizes for the CRC engine sharing arbiter.
// Imported by crc_share_arb and crc_rr_pick.
package crc_share_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DIN_WIDTH = 36;
    localparam int DEF_WIDTH     = 32;

    // Tag ids are sized for the largest supported requester count (16).
    localparam int TAG_ID_W = 4;

    typedef enum logic {
        IDLE,
        HOLD
    } arb_state_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/crc_rr_pick.sv
// Combinational round-robin pick: first valid index strictly after ptr,
// wrapping, so ptr itself is chosen only when it is the sole valid index.
module crc_rr_pick
    import crc_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  pick,
    output logic             any
);

    always_comb begin
        int idx;
        pick = '0;
        any  = 1'b0;
        idx  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!any && valid[idx]) begin
                any  = 1'b1;
                pick = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/crc_share_arb.sv
// Shares one single-word CRC engine among N_REQ requesters with bounded-burst
// round-robin. Define CRC_SHARE_ARB_STATS_EN to add per-requester grant counters.
module crc_share_arb
    import crc_share_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DIN_WIDTH = DEF_DIN_WIDTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ENG_LAT   = 1,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DIN_WIDTH-1:0] req_din,
    output logic [N_REQ-1:0]           req_ready,
    output logic [DIN_WIDTH-1:0]       eng_din,
    output logic                       eng_din_valid,
    input  logic [WIDTH-1:0]           eng_crc,
    input  logic                       eng_crc_valid,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH-1:0]           rsp_crc,
    output logic                       err_sync
`ifdef CRC_SHARE_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]        stat_grants
`endif
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
    localparam logic [2:0] MASK_INIT = 3'(ENG_LAT + 1);

    arb_state_t       state, next_state;
    logic [ID_W-1:0]  owner, next_owner;
    logic [3:0]       burst_cnt, next_burst;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  pick_id;
    logic             pick_any;
    tag_t             tag_pipe [ENG_LAT+1];
    tag_t             tag_head;
    logic [2:0]       mask_cnt;
    logic             sync_err;

    crc_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (owner),
        .pick  (pick_id),
        .any   (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= next_state;
            owner     <= next_owner;
            burst_cnt <= next_burst;
        end
    end

    // At the burst limit the picker returns the owner itself when nobody else
    // waits, so the owner keeps going without a bubble.
    always_comb begin
        next_state  = state;
        next_owner  = owner;
        next_burst  = burst_cnt;
        grant_valid = 1'b0;
        grant_id    = owner;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_valid = 1'b1;
                    grant_id    = pick_id;
                    next_state  = HOLD;
                    next_burst  = 4'd1;
                end
            end
            HOLD: begin
                if (req_valid[owner]) begin
                    grant_valid = 1'b1;
                    if (burst_cnt < BURST_LIM) begin
                        grant_id   = owner;
                        next_burst = burst_cnt + 4'd1;
                    end else begin
                        grant_id   = pick_id;
                        next_burst = 4'd1;
                    end
                end else if (pick_any) begin
                    grant_valid = 1'b1;
                    grant_id    = pick_id;
                    next_burst  = 4'd1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (grant_valid) begin
            next_owner = grant_id;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_valid) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_din       <= '0;
            eng_din_valid <= 1'b0;
        end else begin
            eng_din_valid <= grant_valid;
            if (grant_valid) begin
                eng_din <= req_din[int'(grant_id)*DIN_WIDTH +: DIN_WIDTH];
            end
        end
    end

    // Stage ENG_LAT lines up with eng_crc_valid for the word launched ENG_LAT
    // cycles after it entered stage 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= ENG_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0].valid <= grant_valid;
            tag_pipe[0].id    <= TAG_ID_W'(grant_id);
            for (int i = 1; i <= ENG_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_head = tag_pipe[ENG_LAT];
    assign sync_err = eng_crc_valid ^ tag_head.valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_crc   <= '0;
        end else begin
            rsp_valid <= eng_crc_valid && tag_head.valid;
            if (eng_crc_valid && tag_head.valid) begin
                rsp_id  <= ID_W'(tag_head.id);
                rsp_crc <= eng_crc;
            end
        end
    end

    // Results launched before reset may still emerge; ignore them briefly.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_cnt <= MASK_INIT;
            err_sync <= 1'b0;
        end else begin
            if (mask_cnt != 3'd0) begin
                mask_cnt <= mask_cnt - 3'd1;
            end
            if (sync_err && (mask_cnt == 3'd0)) begin
                err_sync <= 1'b1;
            end
        end
    end

`ifdef CRC_SHARE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants <= '0;
        end else if (grant_valid &&
                     (stat_grants[int'(grant_id)*16 +: 16] != 16'hFFFF)) begin
            stat_grants[int'(grant_id)*16 +: 16] <=
                stat_grants[int'(grant_id)*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crc_share_arb.sv
// Directed self-checking bench for crc_share_arb with a one-cycle engine model
// and a response scoreboard that checks id, CRC and latency of every word.
module tb_crc_share_arb;

    localparam int N   = 4;
    localparam int DW  = 36;
    localparam int CW  = 32;
    localparam int IW  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_din;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   eng_din;
    logic            eng_din_valid;
    logic [CW-1:0]   eng_crc = '0;
    logic            eng_crc_valid = 1'b0;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [CW-1:0]   rsp_crc;
    logic            err_sync;
    logic            inject;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [IW-1:0] id;
        logic [CW-1:0] crc;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];

    crc_share_arb #(
        .N_REQ     (N),
        .DIN_WIDTH (DW),
        .WIDTH     (CW),
        .ENG_LAT   (1),
        .MAX_BURST (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_din       (req_din),
        .req_ready     (req_ready),
        .eng_din       (eng_din),
        .eng_din_valid (eng_din_valid),
        .eng_crc       (eng_crc),
        .eng_crc_valid (eng_crc_valid),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_crc       (rsp_crc),
        .err_sync      (err_sync)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] crc_fn(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        logic          fb;
        c = 32'hFFFF_FFFF;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
        end
        return c;
    endfunction

    // One-step engine; deliberately not reset, like the external block.
    always @(posedge clk) begin
        eng_crc_valid <= eng_din_valid | inject;
        eng_crc       <= crc_fn(eng_din);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back('{id: IW'(i), crc: crc_fn(req_din[i*DW +: DW]), cyc: cyc});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_rsp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
                checkOutput("rsp_crc", 64'(rsp_crc), 64'(e.crc));
                checkOutput("rsp_latency", 64'(cyc - e.cyc), 64'd3);
            end
        end
    end

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] exp_ready,
                                 input bit rand_din, input string tag);
        @(negedge clk);
        req_valid = valid;
        if (rand_din) begin
            for (int i = 0; i < N; i++) begin
                req_din[i*DW +: DW] = DW'({$urandom(), $urandom()});
            end
        end
        #1;
        checkOutput(tag, 64'(req_ready), 64'(exp_ready));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_din   = '0;
        inject    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_eng_din_valid", 64'(eng_din_valid), 64'd0);
        checkOutput("rst_eng_din", 64'(eng_din), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("rst_rsp_crc", 64'(rsp_crc), 64'd0);
        checkOutput("rst_err_sync", 64'(err_sync), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single word from requester 0.
        req_din[0 +: DW] = 36'h8_2340_1230;
        applyStimulus(4'b0001, 4'b0001, 1'b0, "single_ready");
        #1;
        checkOutput("single_ready_no_gate", 64'(req_ready & ~req_valid), 64'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, "single_idle");
        @(negedge clk);
        #1;
        checkOutput("single_eng_din_valid_low", 64'(eng_din_valid), 64'd0);
        repeat (3) @(negedge clk);

        // Park the pointer on requester 3 so the next round starts at 0.
        applyStimulus(4'b1000, 4'b1000, 1'b1, "park3");
        applyStimulus(4'b0000, 4'b0000, 1'b0, "park_idle");

        // All valid: bursts of four, then rotate.
        applyStimulus(4'b1111, 4'b0001, 1'b1, "all_g0a");
        applyStimulus(4'b1111, 4'b0001, 1'b1, "all_g0b");
        applyStimulus(4'b1111, 4'b0001, 1'b1, "all_g0c");
        applyStimulus(4'b1111, 4'b0001, 1'b1, "all_g0d");
        applyStimulus(4'b1111, 4'b0010, 1'b1, "all_g1a");
        applyStimulus(4'b1111, 4'b0010, 1'b1, "all_g1b");
        applyStimulus(4'b1111, 4'b0010, 1'b1, "all_g1c");
        applyStimulus(4'b1111, 4'b0010, 1'b1, "all_g1d");
        applyStimulus(4'b1111, 4'b0100, 1'b1, "all_g2a");
        applyStimulus(4'b1111, 4'b0100, 1'b1, "all_g2b");
        applyStimulus(4'b0000, 4'b0000, 1'b0, "all_idle");

        // Requester 2 alone: no gap across the burst limit.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0100, 4'b0100, 1'b1, $sformatf("solo2_%0d", i));
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0, "solo_idle");

        // Owner 1 drops mid-burst; 3 is next after 1, ahead of 0.
        applyStimulus(4'b0010, 4'b0010, 1'b1, "drop_g1a");
        applyStimulus(4'b1010, 4'b0010, 1'b1, "drop_g1b");
        applyStimulus(4'b1001, 4'b1000, 1'b1, "drop_g3");
        applyStimulus(4'b0000, 4'b0000, 1'b0, "drop_idle");
        repeat (5) @(negedge clk);
        checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
        checkOutput("pre_inject_err", 64'(err_sync), 64'd0);

        // Extra engine result with no tag in flight.
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("inject_err_set", 64'(err_sync), 64'd1);
        applyStimulus(4'b0001, 4'b0001, 1'b1, "post_inject_g0");
        applyStimulus(4'b0000, 4'b0000, 1'b0, "post_inject_idle");
        repeat (5) @(negedge clk);
        checkOutput("inject_err_sticky", 64'(err_sync), 64'd1);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("err_cleared_by_rst", 64'(err_sync), 64'd0);

        // Reset with two words in flight.
        applyStimulus(4'b0001, 4'b0001, 1'b1, "flight_g0");
        applyStimulus(4'b0010, 4'b0010, 1'b1, "flight_g1");
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("flight_err_masked", 64'(err_sync), 64'd0);
        applyStimulus(4'b0100, 4'b0100, 1'b1, "after_rst_g2");
        applyStimulus(4'b0000, 4'b0000, 1'b0, "after_rst_idle");
        repeat (5) @(negedge clk);
        checkOutput("final_err", 64'(err_sync), 64'd0);
        checkOutput("final_pending", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_share_arb.md
# crc_share_arb

Shares one single-word CRC engine among N_REQ requesters. Each cycle it grants at most one requester by round-robin with a bounded burst, and registers the granted word into the engine. It tags the word with the requester index and delays the tag to match the engine latency. It returns each CRC result with its requester index on one broadcast response port. The block sits between the requester front-ends and the external one-step CRC engine; it does not compute CRC itself.

## Interface
- N_REQ, 4, number of requesters (2..16)
- DIN_WIDTH, 36, engine input word width
- WIDTH, 32, CRC width
- ENG_LAT, 1, engine cycles from eng_din_valid to eng_crc_valid (1..4)
- MAX_BURST, 4, maximum consecutive grants to one requester while others wait (1..15)
- ID_W, $clog2(N_REQ), requester index width
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  N_REQ  per-requester word valid
- req_din  in  N_REQ*DIN_WIDTH  per-requester word; slice i = requester i
- req_ready  out  N_REQ  one-hot accept; word i is consumed on the edge where req_valid[i] && req_ready[i]
- eng_din  out  DIN_WIDTH  word to engine
- eng_din_valid  out  1  word to engine valid
- eng_crc  in  WIDTH  engine result
- eng_crc_valid  in  1  engine result valid
- rsp_valid  out  1  response valid; no backpressure
- rsp_id  out  ID_W  requester index of the response
- rsp_crc  out  WIDTH  CRC of that requester's word
- err_sync  out  1  sticky: engine result and tag pipeline out of step

## Operation
- Reset values: req_ready=0, eng_din=0, eng_din_valid=0, rsp_valid=0, rsp_id=0, rsp_crc=0, err_sync=0, owner=0, burst_cnt=0, FSM=IDLE, tag pipeline empty.
- FSM IDLE: no owner. If any req_valid is set, grant the first valid index after the last owner, wrapping; go to HOLD with burst_cnt=1.
- FSM HOLD: keep owner while req_valid[owner] is set and burst_cnt<MAX_BURST; burst_cnt increments per grant.
- burst_cnt==MAX_BURST and another requester valid: rotate to the next valid index after owner; burst_cnt=1.
- burst_cnt==MAX_BURST and no other requester valid: keep owner; burst_cnt=1. No idle cycle is inserted.
- Owner drops req_valid: re-arbitrate in the same cycle from owner+1. If nothing is valid, go to IDLE.
- req_ready is combinational from req_valid and the arbiter state. It is never asserted without the matching req_valid.
- Accepted word is registered to eng_din/eng_din_valid. Its index enters a tag pipeline ENG_LAT+1 deep.
- On eng_crc_valid with the tag head valid: register rsp_crc=eng_crc, rsp_id=tag, rsp_valid=1.
- eng_crc_valid without a tag head, or a tag head without eng_crc_valid: set err_sync, drop the tag, and emit no response.
- err_sync clears only on rst. It is masked for ENG_LAT+1 cycles after rst deasserts, to absorb engine results launched before reset.
- Reset mid-operation: all in-flight tags are discarded; no response is issued for them.

## Timing
- Accept edge t → eng_din_valid high in cycle t+1 → eng_crc_valid at t+1+ENG_LAT → rsp_valid at t+2+ENG_LAT. With ENG_LAT=1 this is 3 cycles.
- Throughput: one word per cycle sustained. Grant switches cost zero bubbles.
- Responses leave in acceptance order. rsp_valid is a single-cycle pulse per word.

## Configuration
- CRC_SHARE_ARB_STATS_EN defined: adds output stat_grants (N_REQ*16). It holds one saturating 16-bit grant counter per requester, cleared by rst.
- Macro undefined: the port and counters are absent; all other behaviour is identical.

## Structure
- Shared package crc_share_pkg holds the FSM state enum (IDLE, HOLD), the tag record typedef (valid, id), and the default N_REQ, DIN_WIDTH and WIDTH constants.
- Sub-module crc_rr_pick: combinational round-robin pick of the next valid index after a given pointer, plus an any-valid flag. Instantiated once.

## Test plan
- Single requester: req_valid=4'b0001, req_din[0]=36'h8_2340_1230, held 1 cycle. Required: req_ready=4'b0001 at once; rsp_valid 3 cycles later with rsp_id=0 and rsp_crc equal to the engine model's result.
- All four valid continuously, MAX_BURST=4: grants are 0,0,0,0,1,1,1,1,2,… Each requester gets a response count equal to its accept count, in order.
- Requester 2 alone valid for 10 cycles: 10 consecutive grants with no gap across the MAX_BURST boundary.
- Owner 1 drops valid mid-burst with 3 valid: requester 3 is granted in the same cycle.
- Engine model forced to emit an extra eng_crc_valid: err_sync=1 and stays 1 until rst; no spurious rsp_valid.
- rst asserted for 1 cycle with 2 words in flight: no rsp_valid for them; err_sync stays 0; the next accepted word responds normally.
